c1541_gcr_dec: RTL and testbench
================================

Name:
c1541_gcr_dec

Overview:
- Read-side GCR deframer/decoder: the receiving end of the 1541 GCR bitstream. Takes a serial GCR bit stream (head/G64 track model) and detects SYNC runs.
- Frames 5-bit quintets, decodes header and data blocks, and verifies checksums.
- Writes the 256 data bytes of each sector into the track buffer RAM at {sector, byte}.
- Sits between the bit-level drive model and the dualport track buffer; used for G64 to D64 write-back.

Parameters:
- SYNC_BITS, 10: consecutive 1 bits that constitute a SYNC.
- ADDR_W, 13: buffer address width, {sector[4:0], byte[7:0]}.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; all state advances only when ce=1
- bit_en  in  1  bit strobe, one clk wide; qualified by ce
- bit_in  in  1  GCR bit, sampled when ce & bit_en
- track  in  6  expected track; data is stored only if the header track matches
- sync_n  out  1  low while a SYNC run (>= SYNC_BITS ones) is in progress
- hdr_valid  out  1  one-clk pulse after header byte 5 (id1) is decoded
- hdr_ok  out  1  last header: checksum good, track match, sector <= 20, no GCR error
- hdr_track  out  6  last header track
- hdr_sector  out  5  last header sector
- hdr_id  out  16  {id1, id2} of last header
- buf_addr  out  ADDR_W  {hdr_sector, byte_index}
- buf_dout  out  8  decoded data byte
- buf_we  out  1  one-clk write strobe
- sec_done  out  1  one-clk pulse after the data checksum byte
- sec_ok  out  1  valid with sec_done: checksum matched and no GCR error
- gcr_err  out  1  one-clk pulse when an invalid quintet is decoded

Behaviour:
- Reset (async) clears all outputs to 0, except sync_n which resets to 1. State returns to HUNT and counters clear. Reset applies mid-block.
- Bit events: ev = ce & bit_en. Nothing changes without ev except that pulse outputs self-clear on the next clk.
- Ones counter, 4 bits, saturating at 15:
  - Increments on a 1 bit, clears on a 0 bit.
  - sync_n = 0 while count >= SYNC_BITS.
- SYNC aborts any state:
  - When the count reaches SYNC_BITS in HDR or DATA, the block is abandoned: no sec_done and no further writes.
  - State goes to SYNC.
- States:
  - HUNT: wait for SYNC, then go to SYNC.
  - SYNC: the first 0 bit after SYNC is bit 4 (MSB) of the first quintet. Bit counter = 1, go to MARK.
  - MARK: decode byte 0.
    - 0x08 -> HDR, byte_idx = 1.
    - 0x07 -> DATA, byte_idx = 0, checksum accumulator = 0.
    - Anything else -> HUNT.
  - HDR: bytes 1..5 are cks, sector, track, id2, id1.
    - After id1, pulse hdr_valid.
    - Latch hdr_ok = (cks == sector^track^id2^id1) & (track[5:0] == track input) & (sector <= 20) & no gcr_err in this header.
    - Then go to HUNT; trailing bytes are ignored.
  - DATA: bytes 0..255 are data, byte 256 is the checksum.
    - Each data byte: accumulator ^= byte. If hdr_ok and no GCR error in this block, then buf_we = 1, buf_addr = {hdr_sector, idx}, buf_dout = byte.
    - Checksum byte: pulse sec_done; sec_ok = (acc == cks) & no GCR error & hdr_ok. Clear hdr_ok (one header authorises one data block). Go to HUNT.
- Framing:
  - Quintets shift MSB-first.
  - High nibble is the first quintet, low nibble the second.
  - A byte completes on its 10th bit event.
  - Outputs (buf_we, hdr_valid, sec_done, gcr_err) are registered and assert exactly 1 clk after that ev.
- GCR decode table (quintet -> nibble):
  - 01010→0, 01011→1, 10010→2, 10011→3, 01110→4, 01111→5, 10110→6, 10111→7
  - 01001→8, 11001→9, 11010→A, 11011→B, 01101→C, 11101→D, 11110→E, 10101→F
  - All other codes are invalid: gcr_err pulse, the nibble is taken as 0, and the block is flagged bad.
  - A block flagged bad stops writing; framing continues.
- Simultaneous events:
  - SYNC completion on the same ev as byte completion: the byte is discarded and SYNC wins.
  - Reset dominates everything.

Decomposition:
- Package c1541_gcr_pkg holds:
  - state enum {HUNT, SYNC, MARK, HDR, DATA}
  - MARK_HDR = 8'h08, MARK_DATA = 8'h07, MAX_SECTOR = 20
  - function gcr_dec5 (5-bit code -> {valid, nibble[3:0]})
- Sub-module c1541_gcr_deframe covers the ones counter, sync_n, quintet shifter and byte-complete strobe. The top level holds the block state machine, checksums and buffer writes.

Test Plan:
- Header decode: 12 ones, then GCR of 08, 12, 03, 12, 41, 42 with track = 18 -> hdr_valid pulse; hdr_sector = 3, hdr_track = 18, hdr_id = 0x4241, hdr_ok = 1.
- Data block: after that header, SYNC then 07, bytes 0x00..0xFF (value = index), checksum 0x00 -> 256 buf_we pulses; buf_addr 0x300..0x3FF, buf_dout = index; sec_done with sec_ok = 1.
- Bad data checksum: same block with checksum 0xFF -> all 256 writes occur; sec_done with sec_ok = 0.
- Invalid quintet: quintet 00000 in data byte 10 -> gcr_err pulse; writes for bytes 0..9 only; sec_ok = 0.
- Mid-block SYNC: 10 ones injected at data byte 100 -> sync_n low, no sec_done. The next header decodes correctly.
- Track mismatch and reset: header track 17 with track input 18 -> hdr_ok = 0 and the following data block makes 0 writes. Reset asserted at data byte 50 -> outputs 0 and sync_n = 1 immediately, state HUNT.

Source files
------------

// File: rtl/c1541_gcr_pkg.sv
// Shared types, mark bytes and the GCR quintet decode table for the 1541 read-side decoder.
package c1541_gcr_pkg;

    typedef enum logic [2:0] {HUNT, SYNC, MARK, HDR, DATA} state_t;

    localparam logic [7:0] MARK_HDR   = 8'h08;
    localparam logic [7:0] MARK_DATA  = 8'h07;
    localparam logic [7:0] MAX_SECTOR = 8'd20;

    // Returns {valid, nibble}; invalid codes decode to nibble 0 with valid clear.
    function automatic logic [4:0] gcr_dec5(input logic [4:0] code);
        logic [4:0] r;
        case (code)
            5'b01010: r = 5'h10;
            5'b01011: r = 5'h11;
            5'b10010: r = 5'h12;
            5'b10011: r = 5'h13;
            5'b01110: r = 5'h14;
            5'b01111: r = 5'h15;
            5'b10110: r = 5'h16;
            5'b10111: r = 5'h17;
            5'b01001: r = 5'h18;
            5'b11001: r = 5'h19;
            5'b11010: r = 5'h1A;
            5'b11011: r = 5'h1B;
            5'b01101: r = 5'h1C;
            5'b11101: r = 5'h1D;
            5'b11110: r = 5'h1E;
            5'b10101: r = 5'h1F;
            default:  r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/c1541_gcr_deframe.sv
// Bit-level front end: ones-run SYNC detector, quintet framing and byte-complete strobe.
module c1541_gcr_deframe
    import c1541_gcr_pkg::*;
#(
    parameter int SYNC_BITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic       sync_n,
    output logic       sync_hit,
    output logic       frame_start,
    output logic       byte_done,
    output logic [7:0] byte_val,
    output logic       byte_err
);

    localparam logic [3:0] SYNC_CNT = 4'(SYNC_BITS);

    logic       ev;
    logic [3:0] ones;
    logic [3:0] ones_next;
    logic [8:0] shreg;
    logic [3:0] bit_cnt;
    logic       framing;
    logic [9:0] word;
    logic [4:0] dec_hi;
    logic [4:0] dec_lo;

    assign ev = ce & bit_en;

    always_comb begin
        ones_next = ones;
        if (!bit_in)
            ones_next = '0;
        else if (ones != 4'hF)
            ones_next = ones + 4'd1;
    end

    // A byte finishing on the same bit that completes a SYNC is dropped.
    assign sync_hit    = ev & (ones_next >= SYNC_CNT);
    assign frame_start = ev & ~bit_in & (ones >= SYNC_CNT);
    assign byte_done   = ev & framing & (bit_cnt == 4'd9) & ~sync_hit;

    assign word     = {shreg, bit_in};
    assign dec_hi   = gcr_dec5(word[9:5]);
    assign dec_lo   = gcr_dec5(word[4:0]);
    assign byte_val = {dec_hi[3:0], dec_lo[3:0]};
    assign byte_err = ~(dec_hi[4] & dec_lo[4]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones    <= '0;
            sync_n  <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            framing <= 1'b0;
        end else if (ev) begin
            ones   <= ones_next;
            sync_n <= ~sync_hit;
            shreg  <= {shreg[7:0], bit_in};
            if (sync_hit) begin
                framing <= 1'b0;
                bit_cnt <= '0;
            end else if (frame_start) begin
                framing <= 1'b1;
                bit_cnt <= 4'd1;
            end else if (framing) begin
                bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/c1541_gcr_dec.sv
// 1541 GCR read-side decoder: block state machine, header/data checksums and track buffer writes.
module c1541_gcr_dec
    import c1541_gcr_pkg::*;
#(
    parameter int SYNC_BITS = 10,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              bit_en,
    input  logic              bit_in,
    input  logic [5:0]        track,
    output logic              sync_n,
    output logic              hdr_valid,
    output logic              hdr_ok,
    output logic [5:0]        hdr_track,
    output logic [4:0]        hdr_sector,
    output logic [15:0]       hdr_id,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_dout,
    output logic              buf_we,
    output logic              sec_done,
    output logic              sec_ok,
    output logic              gcr_err
);

    logic       sync_hit;
    logic       frame_start;
    logic       byte_done;
    logic [7:0] byte_val;
    logic       byte_err;

    state_t     state;
    logic [8:0] idx;
    logic [7:0] acc;
    logic       bad;
    logic [7:0] cks_r;
    logic [7:0] sec_r;
    logic [7:0] trk_r;
    logic [7:0] id2_r;

    c1541_gcr_deframe #(.SYNC_BITS(SYNC_BITS)) u_deframe (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .bit_en     (bit_en),
        .bit_in     (bit_in),
        .sync_n     (sync_n),
        .sync_hit   (sync_hit),
        .frame_start(frame_start),
        .byte_done  (byte_done),
        .byte_val   (byte_val),
        .byte_err   (byte_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            idx        <= '0;
            acc        <= '0;
            bad        <= 1'b0;
            cks_r      <= '0;
            sec_r      <= '0;
            trk_r      <= '0;
            id2_r      <= '0;
            hdr_valid  <= 1'b0;
            hdr_ok     <= 1'b0;
            hdr_track  <= '0;
            hdr_sector <= '0;
            hdr_id     <= '0;
            buf_addr   <= '0;
            buf_dout   <= '0;
            buf_we     <= 1'b0;
            sec_done   <= 1'b0;
            sec_ok     <= 1'b0;
            gcr_err    <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            buf_we    <= 1'b0;
            sec_done  <= 1'b0;
            gcr_err   <= 1'b0;
            // SYNC abandons whatever block was in flight.
            if (sync_hit) begin
                state <= SYNC;
            end else if (frame_start) begin
                state <= MARK;
            end else if (byte_done) begin
                if (state == MARK || state == HDR || state == DATA)
                    gcr_err <= byte_err;
                case (state)
                    MARK: begin
                        bad <= byte_err;
                        if (byte_val == MARK_HDR) begin
                            state <= HDR;
                            idx   <= 9'd1;
                        end else if (byte_val == MARK_DATA) begin
                            state <= DATA;
                            idx   <= 9'd0;
                            acc   <= 8'h00;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    HDR: begin
                        bad <= bad | byte_err;
                        idx <= idx + 9'd1;
                        case (idx[2:0])
                            3'd1: cks_r <= byte_val;
                            3'd2: sec_r <= byte_val;
                            3'd3: trk_r <= byte_val;
                            3'd4: id2_r <= byte_val;
                            3'd5: begin
                                hdr_valid  <= 1'b1;
                                hdr_sector <= sec_r[4:0];
                                hdr_track  <= trk_r[5:0];
                                hdr_id     <= {byte_val, id2_r};
                                hdr_ok     <= (cks_r == (sec_r ^ trk_r ^ id2_r ^ byte_val))
                                              && (trk_r[5:0] == track)
                                              && (sec_r <= MAX_SECTOR)
                                              && !bad && !byte_err;
                                state      <= HUNT;
                            end
                            default: ;
                        endcase
                    end
                    DATA: begin
                        if (!idx[8]) begin
                            acc <= acc ^ byte_val;
                            bad <= bad | byte_err;
                            idx <= idx + 9'd1;
                            if (hdr_ok && !bad && !byte_err) begin
                                buf_we   <= 1'b1;
                                buf_addr <= ADDR_W'({hdr_sector, idx[7:0]});
                                buf_dout <= byte_val;
                            end
                        end else begin
                            // One header authorises exactly one data block.
                            sec_done <= 1'b1;
                            sec_ok   <= (acc == byte_val) && !bad && !byte_err && hdr_ok;
                            hdr_ok   <= 1'b0;
                            state    <= HUNT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_c1541_gcr_dec.sv
// Directed bench for c1541_gcr_dec: GCR-encodes sectors, predicts writes/headers/sector results in queues.
module tb_c1541_gcr_dec;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        bit_en;
    logic        bit_in;
    logic [5:0]  track;
    logic        sync_n;
    logic        hdr_valid;
    logic        hdr_ok;
    logic [5:0]  hdr_track;
    logic [4:0]  hdr_sector;
    logic [15:0] hdr_id;
    logic [12:0] buf_addr;
    logic [7:0]  buf_dout;
    logic        buf_we;
    logic        sec_done;
    logic        sec_ok;
    logic        gcr_err;

    typedef struct packed {
        logic        ok;
        logic [5:0]  trk;
        logic [4:0]  sec;
        logic [15:0] id;
    } hdr_exp_t;

    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int wr_seen = 0;
    int hdr_seen = 0;
    int sec_seen = 0;
    int gerr_seen = 0;
    int gerr_exp = 0;
    int w0;
    int s0;
    int g0;
    int h0;

    hdr_exp_t    hdr_q[$];
    logic [20:0] wr_q[$];
    logic        sec_q[$];
    logic        model_hdr_ok = 1'b0;
    logic [4:0]  model_sector = 5'd0;
    logic        ev_prev;
    hdr_exp_t    he;
    logic [20:0] we_exp;
    logic        so_exp;

    // Nibble -> GCR quintet, the encoding direction of the drive's write path.
    logic [4:0] enc [16] = '{5'b01010, 5'b01011, 5'b10010, 5'b10011,
                             5'b01110, 5'b01111, 5'b10110, 5'b10111,
                             5'b01001, 5'b11001, 5'b11010, 5'b11011,
                             5'b01101, 5'b11101, 5'b11110, 5'b10101};

    c1541_gcr_dec #(.SYNC_BITS(10), .ADDR_W(13)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .bit_en    (bit_en),
        .bit_in    (bit_in),
        .track     (track),
        .sync_n    (sync_n),
        .hdr_valid (hdr_valid),
        .hdr_ok    (hdr_ok),
        .hdr_track (hdr_track),
        .hdr_sector(hdr_sector),
        .hdr_id    (hdr_id),
        .buf_addr  (buf_addr),
        .buf_dout  (buf_dout),
        .buf_we    (buf_we),
        .sec_done  (sec_done),
        .sec_ok    (sec_ok),
        .gcr_err   (gcr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One qualified bit, followed by a ce-gated cycle carrying the opposite bit.
    task automatic apply_stimulus(input logic b);
        @(negedge clk);
        ce = 1'b1; bit_en = 1'b1; bit_in = b;
        if (b) run_len++; else run_len = 0;
        @(negedge clk);
        ce = 1'b0; bit_en = 1'b1; bit_in = ~b;
    endtask

    task automatic send_quintet(input logic [4:0] q);
        for (int i = 4; i >= 0; i--) apply_stimulus(q[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_quintet(enc[b[7:4]]);
        send_quintet(enc[b[3:0]]);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1);
    endtask

    task automatic send_header(input logic [7:0] sec, input logic [7:0] trk,
                               input logic [7:0] id2, input logic [7:0] id1, input logic [7:0] cks_flip);
        logic [7:0] cks;
        hdr_exp_t   e;
        cks   = sec ^ trk ^ id2 ^ id1 ^ cks_flip;
        e.ok  = (cks == (sec ^ trk ^ id2 ^ id1)) && (trk[5:0] == track) && (sec <= 8'd20);
        e.trk = trk[5:0];
        e.sec = sec[4:0];
        e.id  = {id1, id2};
        hdr_q.push_back(e);
        model_hdr_ok = e.ok;
        model_sector = sec[4:0];
        send_sync();
        send_byte(8'h08);
        send_byte(cks);
        send_byte(sec);
        send_byte(trk);
        send_byte(id2);
        send_byte(id1);
    endtask

    // Data byte i carries value i. mode 0: full block, 1: SYNC injected at stop_at, 2: stop mid-byte.
    task automatic send_data(input int stop_at, input int err_at, input logic [7:0] cks_flip, input int mode);
        logic [7:0] acc_rx;
        logic [7:0] acc_tx;
        logic [7:0] b;
        logic       bad;
        int         n;
        acc_rx = 8'h00;
        acc_tx = 8'h00;
        bad    = 1'b0;
        n      = (mode == 0) ? 256 : stop_at;
        for (int i = 0; i < n; i++) begin
            if (i == err_at) begin
                bad = 1'b1;
                gerr_exp++;
                b = {4'h0, 4'(i)};
            end else begin
                b = 8'(i);
            end
            if (model_hdr_ok && !bad) wr_q.push_back({model_sector, 8'(i), 8'(i)});
            acc_rx ^= b;
            acc_tx ^= 8'(i);
        end
        if (mode == 0) begin
            sec_q.push_back((acc_rx == (acc_tx ^ cks_flip)) && !bad && model_hdr_ok);
            model_hdr_ok = 1'b0;
        end
        send_sync();
        send_byte(8'h07);
        for (int i = 0; i < n; i++) begin
            if (i == err_at) begin
                send_quintet(5'b00000);
                send_quintet(enc[4'(i)]);
            end else begin
                send_byte(8'(i));
            end
        end
        if (mode == 0) send_byte(acc_tx ^ cks_flip);
        else if (mode == 1) for (int i = 0; i < 10; i++) apply_stimulus(1'b1);
        else send_quintet(enc[2]);
    endtask

    task automatic check_queues(input string tag);
        check_output({tag, "_wr_left"}, wr_q.size(), 0);
        check_output({tag, "_hdr_left"}, hdr_q.size(), 0);
        check_output({tag, "_sec_left"}, sec_q.size(), 0);
    endtask

    // Compare process: every cycle after the outputs settle.
    always @(posedge clk) begin
        ev_prev = ce & bit_en;
        #2;
        if (!reset) begin
            check_output("sync_n", sync_n, (run_len < 10));
            if (buf_we | hdr_valid | sec_done | gcr_err)
                check_output("pulse_follows_ev", ev_prev, 1);
            if (gcr_err) gerr_seen++;
            if (buf_we) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", buf_addr, buf_dout);
                end else begin
                    we_exp = wr_q.pop_front();
                    check_output("buf_addr", buf_addr, we_exp[20:8]);
                    check_output("buf_dout", buf_dout, we_exp[7:0]);
                end
            end
            if (hdr_valid) begin
                hdr_seen++;
                if (hdr_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_hdr_valid: got 1, expected 0");
                end else begin
                    he = hdr_q.pop_front();
                    check_output("hdr_ok", hdr_ok, he.ok);
                    check_output("hdr_track", hdr_track, he.trk);
                    check_output("hdr_sector", hdr_sector, he.sec);
                    check_output("hdr_id", hdr_id, he.id);
                end
            end
            if (sec_done) begin
                sec_seen++;
                if (sec_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_sec_done: got 1, expected 0");
                end else begin
                    so_exp = sec_q.pop_front();
                    check_output("sec_ok", sec_ok, so_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; ce = 1'b0; bit_en = 1'b0; bit_in = 1'b0; track = 6'd18;
        #1 reset = 1'b1;
        #1;
        check_output("rst_sync_n", sync_n, 1);
        check_output("rst_hdr_ok", hdr_ok, 0);
        check_output("rst_pulses", {hdr_valid, buf_we, sec_done, gcr_err}, 0);
        check_output("rst_buf_addr", buf_addr, 0);
        check_output("rst_hdr_id", hdr_id, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] header decode");
        send_header(8'h03, 8'h12, 8'h41, 8'h42, 8'h00);
        check_output("h1_sector", hdr_sector, 5'd3);
        check_output("h1_track", hdr_track, 6'd18);
        check_output("h1_id", hdr_id, 16'h4241);
        check_output("h1_ok", hdr_ok, 1);
        check_output("h1_count", hdr_seen, 1);

        $display("[TB] good data block");
        w0 = wr_seen; s0 = sec_seen;
        send_data(256, -1, 8'h00, 0);
        check_output("d1_writes", wr_seen - w0, 256);
        check_output("d1_sec_done", sec_seen - s0, 1);
        check_output("d1_sec_ok", sec_ok, 1);
        check_output("d1_last_addr", buf_addr, 13'h3FF);
        check_output("d1_last_dout", buf_dout, 8'hFF);
        check_output("d1_hdr_ok_cleared", hdr_ok, 0);
        check_queues("d1");

        $display("[TB] bad data checksum");
        send_header(8'h03, 8'h12, 8'h41, 8'h42, 8'h00);
        w0 = wr_seen;
        send_data(256, -1, 8'hFF, 0);
        check_output("d2_writes", wr_seen - w0, 256);
        check_output("d2_sec_ok", sec_ok, 0);
        check_queues("d2");

        $display("[TB] invalid quintet in byte 10");
        send_header(8'h03, 8'h12, 8'h41, 8'h42, 8'h00);
        w0 = wr_seen; g0 = gerr_seen;
        send_data(256, 10, 8'h00, 0);
        check_output("d3_writes", wr_seen - w0, 10);
        check_output("d3_gcr_err", gerr_seen - g0, 1);
        check_output("d3_sec_ok", sec_ok, 0);
        check_queues("d3");

        $display("[TB] SYNC inside data block");
        send_header(8'h03, 8'h12, 8'h41, 8'h42, 8'h00);
        w0 = wr_seen; s0 = sec_seen;
        send_data(100, -1, 8'h00, 1);
        check_output("d4_sync_n", sync_n, 0);
        check_output("d4_writes", wr_seen - w0, 100);
        check_output("d4_no_sec_done", sec_seen - s0, 0);
        send_header(8'h05, 8'h12, 8'h33, 8'h44, 8'h00);
        check_output("h5_sector", hdr_sector, 5'd5);
        check_output("h5_id", hdr_id, 16'h4433);
        check_output("h5_ok", hdr_ok, 1);
        check_queues("d4");

        $display("[TB] track mismatch");
        send_header(8'h04, 8'h11, 8'h41, 8'h42, 8'h00);
        check_output("h6_ok", hdr_ok, 0);
        check_output("h6_track", hdr_track, 6'd17);
        w0 = wr_seen;
        send_data(256, -1, 8'h00, 0);
        check_output("d6_writes", wr_seen - w0, 0);
        check_output("d6_sec_ok", sec_ok, 0);

        $display("[TB] sector and checksum boundaries");
        send_header(8'd20, 8'h12, 8'h01, 8'h02, 8'h00);
        check_output("h20_ok", hdr_ok, 1);
        send_header(8'd21, 8'h12, 8'h01, 8'h02, 8'h00);
        check_output("h21_ok", hdr_ok, 0);
        check_output("h21_sector", hdr_sector, 5'd21);
        send_header(8'd7, 8'h12, 8'h01, 8'h02, 8'h40);
        check_output("hcks_ok", hdr_ok, 0);
        check_queues("bnd");

        $display("[TB] reset inside data block");
        send_header(8'h03, 8'h12, 8'h41, 8'h42, 8'h00);
        w0 = wr_seen;
        send_data(50, -1, 8'h00, 2);
        check_output("d8_writes", wr_seen - w0, 50);
        reset = 1'b1;
        run_len = 0;
        model_hdr_ok = 1'b0;
        #1;
        check_output("mid_rst_hdr_ok", hdr_ok, 0);
        check_output("mid_rst_buf_addr", buf_addr, 0);
        check_output("mid_rst_buf_dout", buf_dout, 0);
        check_output("mid_rst_hdr_sector", hdr_sector, 0);
        check_output("mid_rst_sync_n", sync_n, 1);
        @(negedge clk);
        reset = 1'b0;
        h0 = hdr_seen; w0 = wr_seen;
        send_byte(8'h08);
        send_byte(8'h12);
        check_output("post_rst_hunt", (hdr_seen - h0) + (wr_seen - w0), 0);
        send_header(8'h07, 8'h12, 8'h41, 8'h42, 8'h00);
        w0 = wr_seen;
        send_data(256, -1, 8'h00, 0);
        check_output("d9_writes", wr_seen - w0, 256);
        check_output("d9_last_addr", buf_addr, 13'h7FF);
        check_output("d9_sec_ok", sec_ok, 1);
        check_queues("d9");

        $display("[TB] reset during SYNC run");
        send_sync();
        check_output("sync_low", sync_n, 0);
        reset = 1'b1;
        run_len = 0;
        #1;
        check_output("sync_rst", sync_n, 1);
        @(negedge clk);
        reset = 1'b0;

        check_output("gcr_err_total", gerr_seen, gerr_exp);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
